// File: rtl/multicycle_processor.sv
// Multi-cycle RISC core: FSM-sequenced fetch/decode/execute/mem/writeback
// over a shared ALU, internal register file and handshaked external memories.
module multicycle_processor #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 64,
  parameter int IMEM_AW  = 6,
  parameter int DMEM_AW  = 7
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               reg_write_en,
  output logic [5:0]         reg_write_addr,
  output logic [DATA_W-1:0]  reg_write_data,
  output logic [IMEM_AW-1:0] pc,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IMEM_AW-1:0] PC_ONE = 1;

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]  sd_q, sd_d, res_q, res_d;
  logic [DATA_W-1:0]  rf_q [NUM_REGS];

  logic [2:0]         cls, op;
  logic [5:0]         rd, rs, rt;
  logic [DATA_W-1:0]  imm_x, rd_v, rs_v, rt_v, alu_y;
  logic [IMEM_AW-1:0] pc_inc, br_tgt;
  logic               is_alu, is_r, is_mem, is_st, is_beq, is_halt;

  assign cls = ir_q[31:29];
  assign op  = ir_q[28:26];
  assign rd  = ir_q[25:20];
  assign rs  = ir_q[19:14];
  assign rt  = ir_q[13:8];
  assign imm_x = {{(DATA_W-14){ir_q[13]}}, ir_q[13:0]};

  assign is_r    = (cls == 3'b000);
  assign is_alu  = (cls == 3'b000) || (cls == 3'b001);
  assign is_mem  = (cls == 3'b010) || (cls == 3'b011);
  assign is_st   = (cls == 3'b011);
  assign is_beq  = (cls == 3'b100);
  assign is_halt = (cls == 3'b111);

  // r0 and indices beyond the register count read as zero
  assign rd_v = (rd != 0 && int'(rd) < NUM_REGS) ? rf_q[rd[RIW-1:0]] : '0;
  assign rs_v = (rs != 0 && int'(rs) < NUM_REGS) ? rf_q[rs[RIW-1:0]] : '0;
  assign rt_v = (rt != 0 && int'(rt) < NUM_REGS) ? rf_q[rt[RIW-1:0]] : '0;

  assign pc_inc = pc_q + PC_ONE;
  assign br_tgt = pc_inc + imm_x[IMEM_AW-1:0];

  always_comb begin
    alu_y = '0;
    unique case (op)
      3'd0: alu_y = a_q + b_q;
      3'd1: alu_y = a_q - b_q;
      3'd2: alu_y = a_q & b_q;
      3'd3: alu_y = a_q | b_q;
      3'd4: alu_y = a_q ^ b_q;
      3'd5: alu_y = a_q << b_q[4:0];
      3'd6: alu_y = a_q >> b_q[4:0];
      3'd7: alu_y = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    sd_d    = sd_q;
    res_d   = res_q;
    imem_req       = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    reg_write_en   = 1'b0;
    reg_write_addr = '0;
    reg_write_data = '0;
    halted         = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = rst;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs_v;
        b_d     = is_r ? rt_v : imm_x;
        sd_d    = rd_v;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_alu: begin
            res_d   = alu_y;
            state_d = S_WB;
          end
          is_mem: begin
            res_d   = a_q + b_q;
            state_d = S_MEM;
          end
          is_beq: begin
            pc_d    = (sd_q == a_q) ? br_tgt : pc_inc;
            state_d = S_FETCH;
          end
          is_halt: state_d = S_HALT;
          default: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req   = rst;
        dmem_we    = is_st;
        dmem_addr  = res_q[DMEM_AW-1:0];
        dmem_wdata = sd_q;
        if (dmem_ack) begin
          if (is_st) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write_en   = (rd != 0);
        reg_write_addr = rd;
        reg_write_data = res_q;
        pc_d           = pc_inc;
        state_d        = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sd_q    <= sd_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (state_q == S_WB && rd != 0 && int'(rd) < NUM_REGS) begin
      rf_q[rd[RIW-1:0]] <= res_q;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_multicycle_processor.sv
// Scoreboard bench for multicycle_processor: memory models with
// programmable wait states, write-back monitor against queued expectations.
module tb_multicycle_processor;

  logic        clk, rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        reg_write_en, halted;
  logic [5:0]  imem_addr, pc, reg_write_addr;
  logic [6:0]  dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, reg_write_data;

  int checks = 0;
  int errors = 0;
  int cyc_abs = 0;
  int base = 0;
  int stcyc = 0;
  int iwait = 0;
  int dwait = 0;
  int icnt, dcnt;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
    int          c;
  } wb_t;
  wb_t sb[$];

  logic [31:0] imem [64];
  logic [31:0] dmem [128];

  localparam logic [31:0] HALT = 32'hE000_0000;
  localparam logic [31:0] NOP  = 32'hA000_0000;

  multicycle_processor dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .pc(pc), .halted(halted)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  assign imem_ack   = imem_req && (icnt >= iwait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
      if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : wb_mon
    wb_t e;
    if (rst && reg_write_en) begin
      chk("wb_sb", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_addr", {26'b0, reg_write_addr}, {26'b0, e.a});
        chk("wb_data", reg_write_data, e.d);
        chk("wb_cyc", cyc_abs - base + 1, e.c);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && dmem_req && dmem_we) begin
      chk("st_addr", {25'b0, dmem_addr}, 32'd10);
      chk("st_wdata", dmem_wdata, 32'd5);
      stcyc <= stcyc + 1;
    end
  end

  function automatic logic [31:0] ins(input logic [2:0] c,
                                      input logic [2:0] o,
                                      input logic [5:0] rd,
                                      input logic [5:0] rs,
                                      input logic [13:0] imm);
    return {c, o, rd, rs, imm};
  endfunction

  task automatic push(input logic [5:0] a, input logic [31:0] d,
                      input int c);
    wb_t e;
    e.a = a;
    e.d = d;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic hold_reset();
    rst = 0;
    iwait = 0;
    dwait = 0;
    sb.delete();
    for (int i = 0; i < 64; i++) imem[i] = HALT;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1;
    base = cyc_abs;
  endtask

  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && !halted; i++) @(negedge clk);
    chk("halted", {31'b0, halted}, 32'd1);
  endtask

  task automatic wait_sb(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int nreq;
    rst = 0;
    hold_reset();
    #1;
    chk("rst_ireq", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", {26'b0, pc}, 32'd0);
    chk("rst_halt", {31'b0, halted}, 32'd0);
    chk("rst_wen", {31'b0, reg_write_en}, 32'd0);

    // immediate adds, zero-wait fetch
    imem[0] = ins(3'd1, 3'd0, 6'd1, 6'd0, 14'd5);
    imem[1] = ins(3'd1, 3'd0, 6'd2, 6'd1, 14'h3FFD);
    push(6'd1, 32'd5, 4);
    push(6'd2, 32'd2, 8);
    release_rst();
    wait_halt(100);
    chk("t1_sb", sb.size(), 32'd0);
    chk("t1_pc", {26'b0, pc}, 32'd2);

    // R-type SUB/SLT/SLL/SRL
    hold_reset();
    imem[0] = ins(3'd1, 3'd0, 6'd1, 6'd0, 14'd5);
    imem[1] = ins(3'd1, 3'd0, 6'd2, 6'd0, 14'd2);
    imem[2] = ins(3'd0, 3'd1, 6'd3, 6'd2, {6'd1, 8'h00});
    imem[3] = ins(3'd0, 3'd7, 6'd4, 6'd3, {6'd1, 8'h00});
    imem[4] = ins(3'd0, 3'd5, 6'd5, 6'd1, {6'd2, 8'h00});
    imem[5] = ins(3'd0, 3'd6, 6'd7, 6'd3, {6'd2, 8'h00});
    push(6'd1, 32'd5, 4);
    push(6'd2, 32'd2, 8);
    push(6'd3, 32'hFFFF_FFFD, 12);
    push(6'd4, 32'd1, 16);
    push(6'd5, 32'd20, 20);
    push(6'd7, 32'h3FFF_FFFF, 24);
    release_rst();
    wait_halt(100);
    chk("t2_sb", sb.size(), 32'd0);

    // store then load with two dmem wait states
    hold_reset();
    dwait = 2;
    imem[0] = ins(3'd1, 3'd0, 6'd1, 6'd0, 14'd5);
    imem[1] = ins(3'd3, 3'd0, 6'd1, 6'd0, 14'd10);
    imem[2] = ins(3'd2, 3'd0, 6'd6, 6'd0, 14'd10);
    push(6'd1, 32'd5, 4);
    push(6'd6, 32'd5, 17);
    release_rst();
    wait_halt(100);
    chk("st_hold", stcyc, 32'd3);
    chk("st_mem", dmem[10], 32'd5);
    chk("t3_sb", sb.size(), 32'd0);

    // taken BEQ onto itself
    hold_reset();
    for (int i = 0; i < 3; i++) imem[i] = NOP;
    imem[3] = ins(3'd4, 3'd0, 6'd0, 6'd0, 14'h3FFF);
    release_rst();
    repeat (40) @(negedge clk);
    chk("beq_loop_pc", {26'b0, pc}, 32'd3);
    chk("beq_loop_run", {31'b0, halted}, 32'd0);

    // BEQ with unequal operands falls through
    hold_reset();
    imem[0] = ins(3'd1, 3'd0, 6'd1, 6'd0, 14'd5);
    imem[1] = NOP;
    imem[2] = NOP;
    imem[3] = ins(3'd4, 3'd0, 6'd1, 6'd0, 14'd5);
    push(6'd1, 32'd5, 4);
    release_rst();
    wait_halt(100);
    chk("beq_nt_pc", {26'b0, pc}, 32'd4);

    // taken BEQ at the top of imem wraps pc to 0
    hold_reset();
    imem[0] = ins(3'd1, 3'd0, 6'd1, 6'd1, 14'd1);
    for (int i = 1; i < 63; i++) imem[i] = NOP;
    imem[63] = ins(3'd4, 3'd0, 6'd0, 6'd0, 14'd0);
    push(6'd1, 32'd1, 4);
    push(6'd1, 32'd2, 197);
    release_rst();
    wait_sb(300);

    // write to r0 is discarded
    hold_reset();
    imem[0] = ins(3'd1, 3'd0, 6'd0, 6'd0, 14'd7);
    imem[1] = ins(3'd1, 3'd0, 6'd1, 6'd0, 14'd0);
    push(6'd1, 32'd0, 8);
    release_rst();
    repeat (4) @(negedge clk);
    chk("r0_wen", {31'b0, reg_write_en}, 32'd0);
    wait_halt(100);
    chk("t5_sb", sb.size(), 32'd0);

    // HALT stops fetching
    hold_reset();
    release_rst();
    wait_halt(10);
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req) nreq++;
    end
    chk("halt_noreq", nreq, 32'd0);
    chk("halt_hold", {31'b0, halted}, 32'd1);
    chk("halt_pc", {26'b0, pc}, 32'd0);

    // reset in the middle of a stalled load
    hold_reset();
    dwait = 10;
    imem[0] = ins(3'd1, 3'd0, 6'd1, 6'd0, 14'd5);
    imem[1] = ins(3'd2, 3'd0, 6'd2, 6'd0, 14'd3);
    push(6'd1, 32'd5, 4);
    release_rst();
    for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
    chk("mid_mem_req", {31'b0, dmem_req}, 32'd1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_dreq", {31'b0, dmem_req}, 32'd0);
    chk("rst_ireq2", {31'b0, imem_req}, 32'd0);
    chk("rst_pc2", {26'b0, pc}, 32'd0);
    chk("rst_wen2", {31'b0, reg_write_en}, 32'd0);
    chk("rst_sb", sb.size(), 32'd0);
    hold_reset();
    imem[0] = ins(3'd0, 3'd0, 6'd3, 6'd1, {6'd2, 8'h00});
    imem[1] = ins(3'd0, 3'd3, 6'd4, 6'd1, {6'd5, 8'h00});
    push(6'd3, 32'd0, 4);
    push(6'd4, 32'd0, 8);
    release_rst();
    @(negedge clk);
    chk("post_ireq", {31'b0, imem_req}, 32'd1);
    chk("post_iaddr", {26'b0, imem_addr}, 32'd0);
    wait_halt(100);
    chk("t7_sb", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
